// File: rtl/pong_game_sequencer_if.sv
// rtl/pong_game_sequencer_if.sv - control/status bundle between game logic and the pong sequencer
interface pong_game_sequencer_if;
    logic       frame_tick;
    logic       start_l;
    logic       start_r;
    logic       miss_left;
    logic       miss_right;
    logic       move_en;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    modport master (
        output frame_tick, start_l, start_r, miss_left, miss_right,
        input  move_en, ball_reset, serve_dir, score_l, score_r, game_over, winner, state
    );

    modport slave (
        input  frame_tick, start_l, start_r, miss_left, miss_right,
        output move_en, ball_reset, serve_dir, score_l, score_r, game_over, winner, state
    );
endinterface

// File: rtl/pong_game_sequencer.sv
// rtl/pong_game_sequencer.sv - serve/rally/point/game-over sequencer for a two-player pong game
module pong_game_sequencer #(
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pong_game_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        RALLY    = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4,
        PAUSE    = 3'd5
    } state_t;

    localparam logic [7:0] SERVE_LIMIT = 8'(SERVE_FRAMES);
    localparam logic [3:0] WIN_LIMIT   = 4'(WIN_SCORE);

    state_t     state_q;
    logic [7:0] frame_cnt;
    logic [3:0] score_l_q;
    logic [3:0] score_r_q;
    logic       serve_dir_q;
    logic       winner_q;
    logic       start_q;
    logic       start_any;
    logic       start_ev;
    logic       miss_l;
    logic       miss_r;

    assign start_any = bus.start_l | bus.start_r;
    assign start_ev  = start_any & ~start_q;
    assign miss_l    = bus.miss_left;
    assign miss_r    = bus.miss_right;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_cnt   <= 8'd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            serve_dir_q <= 1'b1;
            winner_q    <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            start_q <= start_any;
            case (state_q)
                IDLE: begin
                    score_l_q <= 4'd0;
                    score_r_q <= 4'd0;
                    if (start_ev) begin
                        serve_dir_q <= 1'b1;
                        frame_cnt   <= 8'd0;
                        state_q     <= SERVE;
                    end
                end
                SERVE: begin
                    if (bus.frame_tick) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (frame_cnt + 8'd1 == SERVE_LIMIT)
                            state_q <= RALLY;
                    end
                end
                RALLY: begin
                    // Misses outrank a coincident Start; a double miss is a replay.
                    if (miss_l && miss_r) begin
                        frame_cnt <= 8'd0;
                        state_q   <= SERVE;
                    end else if (miss_l) begin
                        if (score_r_q != WIN_LIMIT)
                            score_r_q <= score_r_q + 4'd1;
                        serve_dir_q <= 1'b0;
                        state_q     <= POINT;
                    end else if (miss_r) begin
                        if (score_l_q != WIN_LIMIT)
                            score_l_q <= score_l_q + 4'd1;
                        serve_dir_q <= 1'b1;
                        state_q     <= POINT;
                    end else if (start_ev) begin
                        state_q <= PAUSE;
                    end
                end
                POINT: begin
                    if (score_l_q == WIN_LIMIT || score_r_q == WIN_LIMIT) begin
                        winner_q <= (score_r_q == WIN_LIMIT);
                        state_q  <= GAMEOVER;
                    end else begin
                        frame_cnt <= 8'd0;
                        state_q   <= SERVE;
                    end
                end
                GAMEOVER: begin
                    if (start_ev) begin
                        score_l_q   <= 4'd0;
                        score_r_q   <= 4'd0;
                        serve_dir_q <= 1'b1;
                        frame_cnt   <= 8'd0;
                        state_q     <= SERVE;
                    end
                end
                PAUSE: begin
                    if (start_ev)
                        state_q <= RALLY;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status outputs decode only registered state, never a live input.
    assign bus.move_en    = (state_q == RALLY);
    assign bus.ball_reset = (state_q == IDLE) || (state_q == SERVE) ||
                            (state_q == POINT) || (state_q == GAMEOVER);
    assign bus.game_over  = (state_q == GAMEOVER);
    assign bus.serve_dir  = serve_dir_q;
    assign bus.score_l    = score_l_q;
    assign bus.score_r    = score_r_q;
    assign bus.winner     = winner_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb/tb_pong_game_sequencer.sv - directed self-checking bench for pong_game_sequencer
module tb_pong_game_sequencer;
    logic clk;
    logic reset_n;
    int   tests;
    int   fails;
    int   pause_entries;
    logic [2:0] prev_state;

    pong_game_sequencer_if bus ();

    pong_game_sequencer #(.SERVE_FRAMES(4), .WIN_SCORE(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic give_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cyc(1);
            bus.frame_tick = 1'b0;
            if (i < n - 1) cyc(1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start_l    = 1'b0;
        bus.start_r    = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        cyc(2);
        check("rst_state", 8'(bus.state), 8'd0);
        check("rst_score_l", 8'(bus.score_l), 8'd0);
        check("rst_score_r", 8'(bus.score_r), 8'd0);
        check("rst_serve_dir", 8'(bus.serve_dir), 8'd1);
        check("rst_winner", 8'(bus.winner), 8'd0);
        check("rst_move_en", 8'(bus.move_en), 8'd0);
        check("rst_ball_reset", 8'(bus.ball_reset), 8'd1);
        check("rst_game_over", 8'(bus.game_over), 8'd0);
        reset_n = 1'b1;
        cyc(1);
        check("idle_hold", 8'(bus.state), 8'd0);

        // Start -> SERVE, misses ignored, 4 ticks to RALLY
        bus.start_l = 1'b1;
        cyc(1);
        bus.start_l = 1'b0;
        check("start_serve", 8'(bus.state), 8'd1);
        check("start_dir", 8'(bus.serve_dir), 8'd1);
        bus.miss_left = 1'b1;
        cyc(1);
        bus.miss_left = 1'b0;
        check("serve_miss_ign", 8'(bus.score_r), 8'd0);
        check("serve_miss_state", 8'(bus.state), 8'd1);
        give_ticks(3);
        cyc(1);
        check("serve_3ticks", 8'(bus.state), 8'd1);
        check("serve_move_en", 8'(bus.move_en), 8'd0);
        give_ticks(1);
        check("rally_state", 8'(bus.state), 8'd2);
        check("rally_move_en", 8'(bus.move_en), 8'd1);
        check("rally_ball_rst", 8'(bus.ball_reset), 8'd0);

        // miss_right -> POINT -> SERVE with score_l=1
        bus.miss_right = 1'b1;
        cyc(1);
        bus.miss_right = 1'b0;
        check("point_state", 8'(bus.state), 8'd3);
        check("point_score_l", 8'(bus.score_l), 8'd1);
        cyc(1);
        check("point_to_serve", 8'(bus.state), 8'd1);
        check("pt_serve_dir", 8'(bus.serve_dir), 8'd1);
        check("pt_ball_reset", 8'(bus.ball_reset), 8'd1);

        // Double miss replay
        give_ticks(4);
        check("rally2", 8'(bus.state), 8'd2);
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        cyc(1);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        check("replay_state", 8'(bus.state), 8'd1);
        check("replay_score_l", 8'(bus.score_l), 8'd1);
        check("replay_score_r", 8'(bus.score_r), 8'd0);
        check("replay_dir", 8'(bus.serve_dir), 8'd1);

        // Held start_r: exactly one PAUSE entry
        give_ticks(4);
        check("rally3", 8'(bus.state), 8'd2);
        pause_entries = 0;
        prev_state = bus.state;
        bus.start_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.state == 3'd5 && prev_state != 3'd5) pause_entries++;
            prev_state = bus.state;
        end
        bus.start_r = 1'b0;
        check("pause_entries", 8'(pause_entries), 8'd1);
        check("pause_state", 8'(bus.state), 8'd5);
        check("pause_move_en", 8'(bus.move_en), 8'd0);
        check("pause_ball_rst", 8'(bus.ball_reset), 8'd0);
        cyc(1);
        bus.miss_left = 1'b1;
        cyc(1);
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b1;
        cyc(1);
        bus.miss_right = 1'b0;
        check("pause_miss_l", 8'(bus.score_l), 8'd1);
        check("pause_miss_r", 8'(bus.score_r), 8'd0);
        check("pause_miss_st", 8'(bus.state), 8'd5);
        bus.start_l = 1'b1;
        cyc(1);
        bus.start_l = 1'b0;
        check("unpause", 8'(bus.state), 8'd2);
        cyc(1);

        // Three left misses -> right wins
        for (int k = 1; k <= 3; k++) begin
            bus.miss_left = 1'b1;
            cyc(1);
            bus.miss_left = 1'b0;
            check("lmiss_point", 8'(bus.state), 8'd3);
            check("lmiss_score_r", 8'(bus.score_r), 8'(k));
            cyc(1);
            if (k < 3) begin
                check("lmiss_serve", 8'(bus.state), 8'd1);
                check("lmiss_dir", 8'(bus.serve_dir), 8'd0);
                give_ticks(4);
            end
        end
        check("go_state", 8'(bus.state), 8'd4);
        check("go_flag", 8'(bus.game_over), 8'd1);
        check("go_winner", 8'(bus.winner), 8'd1);
        check("go_ball_reset", 8'(bus.ball_reset), 8'd1);
        bus.miss_left = 1'b1;
        cyc(1);
        bus.miss_left = 1'b0;
        check("go_sat_r", 8'(bus.score_r), 8'd3);
        check("go_still", 8'(bus.state), 8'd4);
        bus.start_l = 1'b1;
        cyc(1);
        bus.start_l = 1'b0;
        check("restart_state", 8'(bus.state), 8'd1);
        check("restart_l", 8'(bus.score_l), 8'd0);
        check("restart_r", 8'(bus.score_r), 8'd0);
        check("restart_dir", 8'(bus.serve_dir), 8'd1);
        check("restart_go", 8'(bus.game_over), 8'd0);

        // Build score_l=2, reset mid-SERVE after 2 ticks
        for (int k = 1; k <= 2; k++) begin
            give_ticks(4);
            bus.miss_right = 1'b1;
            cyc(1);
            bus.miss_right = 1'b0;
            cyc(1);
        end
        check("pre_rst_score_l", 8'(bus.score_l), 8'd2);
        check("pre_rst_state", 8'(bus.state), 8'd1);
        give_ticks(2);
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        check("mid_rst_state", 8'(bus.state), 8'd0);
        check("mid_rst_l", 8'(bus.score_l), 8'd0);
        check("mid_rst_r", 8'(bus.score_r), 8'd0);
        reset_n = 1'b1;
        cyc(1);
        bus.start_r = 1'b1;
        cyc(1);
        bus.start_r = 1'b0;
        check("post_rst_serve", 8'(bus.state), 8'd1);
        give_ticks(3);
        cyc(1);
        check("post_rst_3ticks", 8'(bus.state), 8'd1);
        give_ticks(1);
        check("post_rst_rally", 8'(bus.state), 8'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
